// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC AXI4-Stream sources onto one stream.
// Define AXIS_ARB_STATS_EN to add per-source packet counters and a total beat counter.
module axis_pkt_rr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 32,
    localparam int ID_BITS = $clog2(N_SRC),
    localparam int KEEP_W  = DATA_W / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [DATA_W-1:0]   s_axis_tdata  [N_SRC],
    input  logic [KEEP_W-1:0]   s_axis_tkeep  [N_SRC],
    input  logic [N_SRC-1:0]    s_axis_tlast,
    input  logic [N_SRC-1:0]    s_axis_tvalid,
    output logic [N_SRC-1:0]    s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [KEEP_W-1:0]   m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [ID_BITS-1:0]  m_id,
    output logic                busy,
    output logic                o_dbg_state
`ifdef AXIS_ARB_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         stat_pkts [N_SRC],
    output logic [31:0]         stat_beats
`endif
);

    // valid/ready: a beat moves on a rising aclk edge where tvalid && tready are both high;
    // a source keeps tdata/tkeep/tlast stable while tvalid is high and tready is low.

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]          r_state;
    logic [ID_BITS-1:0]  r_grant;
    logic [ID_BITS-1:0]  r_rr_ptr;

    logic                w_found;
    logic [ID_BITS-1:0]  w_pick;
    int                  w_idx;
    logic                w_lock;
    logic                w_hs;
    logic                w_eop;

    // Search order starts at the round-robin pointer and wraps modulo N_SRC, not 2^ID_BITS.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_SRC) begin
                w_idx = w_idx - N_SRC;
            end
            if (!w_found && s_axis_tvalid[w_idx[ID_BITS-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[ID_BITS-1:0];
            end
        end
    end

    assign w_lock = (r_state == ST_LOCK);
    assign w_hs   = m_axis_tvalid && m_axis_tready;
    assign w_eop  = w_hs && m_axis_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_eop) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= (r_grant == ID_BITS'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The data path is a plain mux on the grant; only tvalid/tready are gated by the lock.
    assign m_axis_tdata  = s_axis_tdata[r_grant];
    assign m_axis_tkeep  = s_axis_tkeep[r_grant];
    assign m_axis_tlast  = s_axis_tlast[r_grant];
    assign m_axis_tvalid = w_lock && s_axis_tvalid[r_grant];

    always_comb begin
        s_axis_tready = '0;
        if (w_lock) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    assign m_id        = r_grant;
    assign busy        = w_lock;
    assign o_dbg_state = r_state;

`ifdef AXIS_ARB_STATS_EN
    logic [31:0] r_stat_pkts [N_SRC];
    logic [31:0] r_stat_beats;

    // Clear wins over a same-cycle increment; counters wrap naturally at 32 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_stat_pkts[i] <= '0;
            end
            r_stat_beats <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_stat_pkts[i] <= '0;
            end
            r_stat_beats <= '0;
        end else begin
            if (w_hs) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (w_eop) begin
                r_stat_pkts[r_grant] <= r_stat_pkts[r_grant] + 32'd1;
            end
        end
    end

    assign stat_pkts  = r_stat_pkts;
    assign stat_beats = r_stat_beats;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed self-checking bench for axis_pkt_rr_arbiter (N_SRC=4, 32-bit data).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_axis_pkt_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          aclk;
    logic          aresetn;
    logic [DW-1:0] s_tdata [N];
    logic [3:0]    s_tkeep [N];
    logic [N-1:0]  s_tlast;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tready;
    logic [DW-1:0] m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [1:0]    m_id;
    logic          busy;
    logic          dbg_state;
`ifdef AXIS_ARB_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_pkts [N];
    logic [31:0]   stat_beats;
`endif

    int            total;
    int            bad;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_beat;
    logic [N-1:0]  hs;
    int            beat [N];
    int            pkt  [N];

    axis_pkt_rr_arbiter #(
        .N_SRC  (N),
        .DATA_W (DW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_id          (m_id),
        .busy          (busy),
        .o_dbg_state   (dbg_state)
`ifdef AXIS_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_pkts     (stat_pkts),
        .stat_beats    (stat_beats)
`endif
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // driver
    task automatic set_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        s_tvalid[i] = v;
        s_tdata[i]  = d;
        s_tkeep[i]  = 4'hF;
        s_tlast[i]  = l;
    endtask

    function automatic logic [DW-1:0] mk(input int s, input int p, input int b);
        return DW'((s << 8) | (p << 4) | b);
    endfunction

    // scoreboard comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        hs    = '0;
        for (int i = 0; i < N; i++) begin
            set_src(i, 1'b0, '0, 1'b0);
            beat[i] = 0;
            pkt[i]  = 0;
        end
        m_tready = 1'b1;
`ifdef AXIS_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        aresetn = 1'b0;
        #2;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mid", m_id, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // sources 0 and 2 request single-beat packets together
        cyc(); set_src(0, 1'b1, 32'hA0, 1'b1); set_src(2, 1'b1, 32'hA2, 1'b1); smp();
        chk("t1_idle_tvalid", m_tvalid, 0);
        chk("t1_idle_tready", s_tready, 4'b0000);
        cyc(); smp();
        chk("t1_g0_tvalid", m_tvalid, 1);
        chk("t1_g0_mid", m_id, 0);
        chk("t1_g0_data", m_tdata, 32'hA0);
        chk("t1_g0_tlast", m_tlast, 1);
        chk("t1_g0_tkeep", m_tkeep, 4'hF);
        chk("t1_g0_tready", s_tready, 4'b0001);
        chk("t1_g0_busy", busy, 1);
        cyc(); set_src(0, 1'b0, '0, 1'b0); smp();
        chk("t1_bubble_tvalid", m_tvalid, 0);
        chk("t1_bubble_busy", busy, 0);
        cyc(); smp();
        chk("t1_g2_tvalid", m_tvalid, 1);
        chk("t1_g2_mid", m_id, 2);
        chk("t1_g2_data", m_tdata, 32'hA2);
        chk("t1_g2_tready", s_tready, 4'b0100);
        cyc(); set_src(2, 1'b0, '0, 1'b0);

        // all sources stream 3-beat packets continuously
        do_reset();
        exp_q.delete();
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 3; b++) begin
                exp_q.push_back(mk(p % 4, p / 4, b));
            end
        end
        for (int c = 0; c < 20; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if (beat[i] == 2) begin
                        beat[i] = 0;
                        pkt[i]  = pkt[i] + 1;
                    end else begin
                        beat[i] = beat[i] + 1;
                    end
                end
                set_src(i, 1'b1, mk(i, pkt[i], beat[i]), beat[i] == 2);
            end
            smp();
            chk("t2_tvalid_pattern", m_tvalid, (c % 4) != 0);
            if (m_tvalid && m_tready) begin
                chk("t2_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    chk("t2_data", m_tdata, exp_beat);
                    chk("t2_mid", m_id, exp_beat[9:8]);
                    chk("t2_tlast", m_tlast, exp_beat[3:0] == 4'd2);
                    chk("t2_tready", s_tready, 4'b0001 << exp_beat[9:8]);
                end
            end
            hs = s_tvalid & s_tready;
        end
        chk("t2_q_drained", exp_q.size(), 0);
        cyc();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, 1'b0);

        // source 1 4-beat packet with a 5-cycle downstream stall before beat 3
        do_reset();
        cyc(); set_src(1, 1'b1, 32'h10, 1'b0); smp();
        chk("t3_idle_tvalid", m_tvalid, 0);
        cyc(); set_src(0, 1'b1, 32'hE0, 1'b1); set_src(2, 1'b1, 32'hE2, 1'b1); smp();
        chk("t3_b1_mid", m_id, 1);
        chk("t3_b1_data", m_tdata, 32'h10);
        chk("t3_b1_tready", s_tready, 4'b0010);
        cyc(); set_src(1, 1'b1, 32'h11, 1'b0); smp();
        chk("t3_b2_data", m_tdata, 32'h11);
        chk("t3_b2_tready", s_tready, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k == 0) set_src(1, 1'b1, 32'h12, 1'b0);
            m_tready = 1'b0;
            smp();
            chk("t3_stall_tvalid", m_tvalid, 1);
            chk("t3_stall_data", m_tdata, 32'h12);
            chk("t3_stall_mid", m_id, 1);
            chk("t3_stall_tready", s_tready, 4'b0000);
            chk("t3_stall_busy", busy, 1);
        end
        cyc(); m_tready = 1'b1; smp();
        chk("t3_b3_data", m_tdata, 32'h12);
        chk("t3_b3_tready", s_tready, 4'b0010);
        cyc(); set_src(1, 1'b1, 32'h13, 1'b1); smp();
        chk("t3_b4_data", m_tdata, 32'h13);
        chk("t3_b4_tlast", m_tlast, 1);
        cyc(); set_src(1, 1'b0, '0, 1'b0); smp();
        chk("t3_bubble_busy", busy, 0);
        cyc(); smp();
        chk("t3_next_mid", m_id, 2);
        chk("t3_next_data", m_tdata, 32'hE2);
        cyc();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, 1'b0);

        // source 3 drops tvalid mid-packet; then wrap and reset mid-packet
        do_reset();
        cyc(); set_src(3, 1'b1, 32'h30, 1'b0); smp();
        chk("t4_idle_tvalid", m_tvalid, 0);
        cyc(); smp();
        chk("t4_b1_mid", m_id, 3);
        chk("t4_b1_data", m_tdata, 32'h30);
        for (int k = 0; k < 2; k++) begin
            cyc();
            if (k == 0) begin
                set_src(3, 1'b0, 32'h30, 1'b0);
                set_src(0, 1'b1, 32'h0F, 1'b1);
            end
            smp();
            chk("t4_gap_tvalid", m_tvalid, 0);
            chk("t4_gap_busy", busy, 1);
            chk("t4_gap_mid", m_id, 3);
            chk("t4_gap_tready", s_tready, 4'b1000);
        end
        cyc(); set_src(3, 1'b1, 32'h31, 1'b1); smp();
        chk("t4_b2_tvalid", m_tvalid, 1);
        chk("t4_b2_data", m_tdata, 32'h31);
        chk("t4_b2_tlast", m_tlast, 1);
        chk("t4_b2_mid", m_id, 3);
        cyc(); set_src(3, 1'b0, '0, 1'b0); set_src(0, 1'b0, '0, 1'b0); set_src(1, 1'b1, 32'h50, 1'b1); smp();
        chk("t4_bubble_busy", busy, 0);
        cyc(); smp();
        chk("t4_wrap_mid", m_id, 1);
        chk("t4_wrap_data", m_tdata, 32'h50);
        cyc(); set_src(1, 1'b0, '0, 1'b0); set_src(0, 1'b1, 32'h60, 1'b1); set_src(2, 1'b1, 32'h70, 1'b0); smp();
        chk("t5_idle_tvalid", m_tvalid, 0);
        cyc(); smp();
        chk("t5_rr_mid", m_id, 2);
        chk("t5_rr_data", m_tdata, 32'h70);
        cyc(); set_src(2, 1'b1, 32'h71, 1'b0); smp();
        chk("t5_b2_tvalid", m_tvalid, 1);
        chk("t5_b2_data", m_tdata, 32'h71);
        #1 aresetn = 1'b0;
        #1;
        chk("t5_arst_tvalid", m_tvalid, 0);
        chk("t5_arst_busy", busy, 0);
        chk("t5_arst_mid", m_id, 0);
        chk("t5_arst_tready", s_tready, 4'b0000);
        chk("t5_arst_state", dbg_state, 0);
        cyc(); aresetn = 1'b1; smp();
        chk("t5_post_idle", m_tvalid, 0);
        cyc(); smp();
        chk("t5_post_mid", m_id, 0);
        chk("t5_post_data", m_tdata, 32'h60);
        chk("t5_post_tvalid", m_tvalid, 1);
        cyc();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, 1'b0);

`ifdef AXIS_ARB_STATS_EN
        // five 2-beat packets from source 2, then a counter clear
        do_reset();
        for (int p = 0; p < 5; p++) begin
            cyc(); set_src(2, 1'b1, mk(2, p, 0), 1'b0); smp();
            cyc(); smp();
            cyc(); set_src(2, 1'b1, mk(2, p, 1), 1'b1); smp();
        end
        cyc(); set_src(2, 1'b0, '0, 1'b0); smp();
        chk("st_pkts2", stat_pkts[2], 5);
        chk("st_pkts0", stat_pkts[0], 0);
        chk("st_beats", stat_beats, 10);
        cyc(); stat_clr = 1'b1; smp();
        cyc(); stat_clr = 1'b0; smp();
        chk("st_clr_pkts2", stat_pkts[2], 0);
        chk("st_clr_beats", stat_beats, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
